// File: rtl/apb_to_obi_narrow.sv
// APB subordinate to narrow OBI manager bridge: each APB access is split into
// Ratio sequential OBI beats, with strobe-based beat skipping and error accumulation.
package apb_to_obi_narrow_pkg;

  typedef struct packed {
    bit          UseRReady;
    bit          Integrity;
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned AChkWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b1,
    Integrity: 1'b0,
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   1,
    AChkWidth: 0
  };

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic [2:0]  pprot;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [63:0] prdata;
    logic        pslverr;
  } apb_rsp_t;

  typedef struct packed {
    logic [5:0] atop;
    logic [1:0] memtype;
    logic [2:0] prot;
    logic       dbg;
  } obi_a_optional_t;

  typedef struct packed {
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [0:0]      aid;
    obi_a_optional_t a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_RESP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// Handshakes: OBI A-channel transfers on req && gnt (req held with stable fields
// until gnt); R-channel transfers on rvalid (rready tied high); APB completes on pready.
module apb_to_obi_narrow #(
  parameter apb_to_obi_narrow_pkg::obi_cfg_t ObiCfg = apb_to_obi_narrow_pkg::ObiDefaultConfig,
  parameter int unsigned ApbDataWidth = 64,
  parameter bit          AbortOnErr   = 1'b0,
  parameter type apb_req_t = apb_to_obi_narrow_pkg::apb_req_t,
  parameter type apb_rsp_t = apb_to_obi_narrow_pkg::apb_rsp_t,
  parameter type obi_req_t = apb_to_obi_narrow_pkg::obi_req_t,
  parameter type obi_rsp_t = apb_to_obi_narrow_pkg::obi_rsp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  apb_req_t                       apb_req_i,
  output apb_rsp_t                       apb_rsp_o,
  output obi_req_t                       obi_req_o,
  input  obi_rsp_t                       obi_rsp_i,
  output apb_to_obi_narrow_pkg::state_e  dbg_state
);
  import apb_to_obi_narrow_pkg::*;

  localparam int unsigned ObiDw   = ObiCfg.DataWidth;
  localparam int unsigned ObiBw   = ObiDw / 8;
  localparam int unsigned AW      = ObiCfg.AddrWidth;
  localparam int unsigned Ratio   = ApbDataWidth / ObiDw;
  localparam int unsigned BeatW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned ApbOffW = $clog2(ApbDataWidth / 8);
  localparam int unsigned ObiOffW = $clog2(ObiBw);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  state_e                       state_q, state_d;
  logic [BeatW-1:0]             beat_q, beat_d;
  logic                         err_q, err_d;
  logic [Ratio-1:0][ObiDw-1:0]  rdata_q, rdata_d;

  logic [Ratio-1:0][ObiDw-1:0]  wdata_beats;
  logic [Ratio-1:0][ObiBw-1:0]  strb_beats;
  logic [ObiDw-1:0]             cur_wdata;
  logic [ObiBw-1:0]             cur_strb;
  logic [AW-1:0]                base_addr;
  logic [AW-1:0]                beat_addr;
  logic                         apb_active;
  logic                         last_beat;
  logic                         skip_beat;
  logic                         obi_req;
  logic                         pready;

  assign wdata_beats = apb_req_i.pwdata;
  assign strb_beats  = apb_req_i.pstrb;
  assign cur_wdata   = wdata_beats[beat_q];
  assign cur_strb    = strb_beats[beat_q];
  assign apb_active  = apb_req_i.psel && apb_req_i.penable;
  assign last_beat   = (beat_q == LastBeat);
  // A write beat whose strobe slice is empty carries no data and is never sent.
  assign skip_beat   = apb_req_i.pwrite && (cur_strb == '0);

  assign base_addr = {apb_req_i.paddr[AW-1:ApbOffW], {ApbOffW{1'b0}}};
  assign beat_addr = base_addr | (AW'(beat_q) << ObiOffW);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ADDR;
      beat_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    obi_req = 1'b0;
    pready  = 1'b0;
    unique case (state_q)
      ST_ADDR: begin
        if (apb_active) begin
          if (skip_beat) begin
            if (last_beat) state_d = ST_DONE;
            else           beat_d  = beat_q + BeatW'(1);
          end else begin
            obi_req = 1'b1;
            if (obi_rsp_i.gnt) state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (obi_rsp_i.rvalid) begin
          // Write responses may carry arbitrary rdata; only reads fill prdata.
          if (!apb_req_i.pwrite) rdata_d[beat_q] = obi_rsp_i.r.rdata;
          err_d = err_q | obi_rsp_i.r.err;
          if (last_beat || (AbortOnErr && obi_rsp_i.r.err)) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            state_d = ST_ADDR;
          end
        end
      end
      ST_DONE: begin
        pready  = 1'b1;
        state_d = ST_ADDR;
        beat_d  = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_comb begin
    obi_req_o                      = '0;
    obi_req_o.req                  = obi_req;
    obi_req_o.a.addr               = beat_addr;
    obi_req_o.a.we                 = apb_req_i.pwrite;
    obi_req_o.a.be                 = apb_req_i.pwrite ? cur_strb : '1;
    obi_req_o.a.wdata              = cur_wdata;
    obi_req_o.a.aid                = '0;
    obi_req_o.a.a_optional.prot    = {{2{apb_req_i.pprot[0]}}, ~apb_req_i.pprot[2]};
    obi_req_o.rready               = ObiCfg.UseRReady;
  end

  always_comb begin
    apb_rsp_o         = '0;
    apb_rsp_o.pready  = pready;
    apb_rsp_o.prdata  = pready ? rdata_q : '0;
    apb_rsp_o.pslverr = pready ? err_q : 1'b0;
  end

  assign dbg_state = state_q;

  logic unused_bits;
  assign unused_bits = ^{apb_req_i.paddr[ApbOffW-1:0], apb_req_i.pprot[1], obi_rsp_i.r.rid};

`ifndef OBI_ASSERTS_OFF
  if ((Ratio == 0) || (ApbDataWidth != Ratio * ObiDw) || ((Ratio & (Ratio - 1)) != 0)) begin : g_bad_ratio
    $error("ApbDataWidth must be a power-of-two multiple of the OBI data width");
  end
  if (ObiCfg.Integrity || (ObiCfg.AChkWidth != 0)) begin : g_bad_integrity
    $error("OBI integrity is not supported");
  end
  if ($bits(apb_req_i.paddr) != AW) begin : g_bad_addr
    $error("APB and OBI address widths must match");
  end

  // Mid-access the APB master must hold its request steady.
  a_apb_held: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q != ST_ADDR) || (beat_q != '0)) |->
      (apb_req_i.psel && apb_req_i.penable &&
       $stable(apb_req_i.paddr) && $stable(apb_req_i.pwrite)));
`endif

endmodule

// File: tb/tb_apb_to_obi_narrow.sv
// Bench for apb_to_obi_narrow: two instances (AbortOnErr 0 and 1), an OBI memory
// responder with per-access stalls, and a beat-level reference model feeding a scoreboard.
module tb_apb_to_obi_narrow;
  import apb_to_obi_narrow_pkg::*;

  typedef struct packed {
    logic        k;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic        rready;
  } beat_t;

  typedef struct packed {
    logic        k;
    logic [63:0] prdata;
    logic        pslverr;
    logic [31:0] cyc;
  } apb_exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb_req_t apb_req [2];
  apb_rsp_t apb_rsp [2];
  obi_req_t obi_req [2];
  obi_rsp_t obi_rsp [2];
  state_e   dbg     [2];

  apb_to_obi_narrow #(.AbortOnErr(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .apb_req_i(apb_req[0]), .apb_rsp_o(apb_rsp[0]),
    .obi_req_o(obi_req[0]), .obi_rsp_i(obi_rsp[0]), .dbg_state(dbg[0]));

  apb_to_obi_narrow #(.AbortOnErr(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .apb_req_i(apb_req[1]), .apb_rsp_o(apb_rsp[1]),
    .obi_req_o(obi_req[1]), .obi_rsp_i(obi_rsp[1]), .dbg_state(dbg[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  beat_t    exp_obi_q [$];
  apb_exp_t exp_apb_q [$];

  logic [31:0] ref_mem [logic [32:0]];
  logic [31:0] env_mem [logic [32:0]];

  int          gnt_dly  [2];
  int          rv_dly   [2];
  int          gnt_wait [2];
  int          rv_wait  [2];
  bit          pend     [2];
  logic [31:0] pend_data[2];
  logic        pend_err [2];
  obi_a_chan_t held_a   [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Error region: low word of every 8-byte line at 0xE00..0xEFF.
  function automatic logic err_of(input logic [31:0] a);
    return (a[11:8] == 4'hE) && !a[2];
  endfunction

  // reference model: walks the beats of one access and predicts traffic and response
  task automatic model_access(input int k, input logic [31:0] addr, input logic wr,
                              input logic [63:0] wdata, input logic [7:0] strb,
                              input logic [2:0] pprot, input int start);
    logic [31:0] base, a, cur;
    logic [3:0]  s;
    logic [63:0] rd;
    logic        err, e;
    logic [32:0] key;
    int          lat;
    base = {addr[31:3], 3'b000};
    rd   = '0;
    err  = 1'b0;
    lat  = 0;
    for (int b = 0; b < 2; b++) begin
      a = base + 32'(4 * b);
      s = strb[4*b +: 4];
      if (wr && (s == 4'h0)) begin
        lat++;
        continue;
      end
      exp_obi_q.push_back('{k: k[0], addr: a, we: wr, be: (wr ? s : 4'hF),
                            wdata: wdata[32*b +: 32],
                            prot: {{2{pprot[0]}}, ~pprot[2]}, rready: 1'b1});
      key = {k[0], a};
      cur = ref_mem.exists(key) ? ref_mem[key] : init_word(a);
      if (wr) begin
        for (int j = 0; j < 4; j++) if (s[j]) cur[8*j +: 8] = wdata[32*b + 8*j +: 8];
        ref_mem[key] = cur;
      end else begin
        rd[32*b +: 32] = cur;
      end
      lat += 2 + gnt_dly[k] + rv_dly[k];
      e    = err_of(a);
      err  = err | e;
      if ((k == 1) && e) break;
    end
    exp_apb_q.push_back('{k: k[0], prdata: (wr ? 64'h0 : rd), pslverr: err,
                          cyc: 32'(start + lat)});
  endtask

  // driver: one full APB access on instance k with the given OBI stall profile
  task automatic apb_access(input int k, input logic [31:0] addr, input logic wr,
                            input logic [63:0] wdata, input logic [7:0] strb,
                            input logic [2:0] pprot, input int gd, input int rd);
    bit got;
    @(posedge clk); #1;
    gnt_dly[k] = gd;
    rv_dly[k]  = rd;
    apb_req[k] = '{psel: 1'b1, penable: 1'b0, paddr: addr, pwrite: wr,
                   pwdata: wdata, pstrb: strb, pprot: pprot};
    @(posedge clk); #1;
    apb_req[k].penable = 1'b1;
    model_access(k, addr, wr, wdata, strb, pprot, cyc);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (apb_rsp[k].pready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("pready_timeout", 0, 1);
    @(posedge clk); #1;
    apb_req[k].psel    = 1'b0;
    apb_req[k].penable = 1'b0;
  endtask

  task automatic reset_mid_resp();
    bit seen;
    @(posedge clk); #1;
    gnt_dly[0] = 0;
    rv_dly[0]  = 3;
    apb_req[0] = '{psel: 1'b1, penable: 1'b0, paddr: 32'h200, pwrite: 1'b0,
                   pwdata: 64'h0, pstrb: 8'h00, pprot: 3'b000};
    @(posedge clk); #1;
    apb_req[0].penable = 1'b1;
    exp_obi_q.push_back('{k: 1'b0, addr: 32'h200, we: 1'b0, be: 4'hF, wdata: 32'h0,
                          prot: 3'b001, rready: 1'b1});
    @(posedge clk); #1;
    check("resp_before_rst", dbg[0], ST_RESP);
    rst        = 1'b1;
    apb_req[0] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("state_after_rst", dbg[0], ST_ADDR);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      seen = seen | apb_rsp[0].pready;
    end
    check("no_pready_after_rst", seen, 0);
    check("state_after_stale", dbg[0], ST_ADDR);
  endtask

  task automatic obi_respond(input int k);
    logic [32:0] key;
    logic [31:0] cur;
    obi_rsp[k] = '0;
    if (pend[k]) begin
      if (rv_wait[k] > 0) begin
        rv_wait[k]--;
      end else begin
        obi_rsp[k].rvalid  = 1'b1;
        obi_rsp[k].r.rdata = pend_data[k];
        obi_rsp[k].r.err   = pend_err[k];
        pend[k]            = 1'b0;
      end
    end else if (obi_req[k].req === 1'b1) begin
      if (gnt_wait[k] == 0) held_a[k] = obi_req[k].a;
      else check("a_stable", obi_req[k].a, held_a[k]);
      if (gnt_wait[k] < gnt_dly[k]) begin
        gnt_wait[k]++;
      end else begin
        obi_rsp[k].gnt = 1'b1;
        gnt_wait[k]    = 0;
        key = {k[0], obi_req[k].a.addr};
        cur = env_mem.exists(key) ? env_mem[key] : init_word(obi_req[k].a.addr);
        if (obi_req[k].a.we) begin
          for (int j = 0; j < 4; j++)
            if (obi_req[k].a.be[j]) cur[8*j +: 8] = obi_req[k].a.wdata[8*j +: 8];
          env_mem[key] = cur;
          pend_data[k] = 32'hBAD0_0000 | {16'h0, obi_req[k].a.addr[15:0]};
        end else begin
          pend_data[k] = cur;
        end
        pend_err[k] = err_of(obi_req[k].a.addr);
        pend[k]     = 1'b1;
        rv_wait[k]  = rv_dly[k];
      end
    end else begin
      gnt_wait[k] = 0;
    end
  endtask

  // OBI subordinate model: not affected by the bridge reset
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) obi_respond(k);
    end
  end

  // scoreboard monitor
  initial begin
    beat_t    act_b, exp_b;
    apb_exp_t exp_r;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        for (int k = 0; k < 2; k++) begin
          check("req_gated", obi_req[k].req & ~(apb_req[k].psel & apb_req[k].penable), 0);
          if (obi_req[k].req && obi_rsp[k].gnt) begin
            act_b = '{k: k[0], addr: obi_req[k].a.addr, we: obi_req[k].a.we,
                      be: obi_req[k].a.be, wdata: obi_req[k].a.wdata,
                      prot: obi_req[k].a.a_optional.prot, rready: obi_req[k].rready};
            if (exp_obi_q.size() == 0) begin
              check("obi_unexpected_beat", act_b, 0);
            end else begin
              exp_b = exp_obi_q.pop_front();
              check("obi_beat", act_b, exp_b);
            end
          end
          if (apb_rsp[k].pready) begin
            if (exp_apb_q.size() == 0) begin
              check("apb_unexpected_pready", k, 99);
            end else begin
              exp_r = exp_apb_q.pop_front();
              check("apb_inst", k[0], exp_r.k);
              check("apb_prdata", apb_rsp[k].prdata, exp_r.prdata);
              check("apb_pslverr", apb_rsp[k].pslverr, exp_r.pslverr);
              check("apb_latency", cyc, exp_r.cyc);
            end
          end else begin
            check("idle_rsp", {apb_rsp[k].prdata, apb_rsp[k].pslverr}, 0);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] addr;
    logic        wr;
    logic [63:0] wd;
    logic [7:0]  strb;
    for (int i = 0; i < 2; i++) begin
      apb_req[i]  = '0;
      obi_rsp[i]  = '0;
      gnt_dly[i]  = 0;
      rv_dly[i]   = 0;
      gnt_wait[i] = 0;
      rv_wait[i]  = 0;
      pend[i]     = 1'b0;
      pend_data[i] = '0;
      pend_err[i] = 1'b0;
      held_a[i]   = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_pready", apb_rsp[i].pready, 0);
      check("rst_prdata", apb_rsp[i].prdata, 0);
      check("rst_pslverr", apb_rsp[i].pslverr, 0);
      check("rst_req", obi_req[i].req, 0);
      check("rst_state", dbg[i], ST_ADDR);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      ref_mem[{i[0], 32'h100}] = 32'h1111_1111;
      ref_mem[{i[0], 32'h104}] = 32'h2222_2222;
      env_mem[{i[0], 32'h100}] = 32'h1111_1111;
      env_mem[{i[0], 32'h104}] = 32'h2222_2222;
    end

    // directed cases
    apb_access(0, 32'h104, 1'b0, 64'h0, 8'h00, 3'b000, 0, 0);
    apb_access(0, 32'h100, 1'b1, 64'hAABBCCDD_01234567, 8'hF0, 3'b010, 0, 0);
    apb_access(0, 32'h108, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'b101, 0, 0);
    apb_access(0, 32'hE00, 1'b0, 64'h0, 8'h00, 3'b000, 0, 0);
    apb_access(1, 32'hE00, 1'b0, 64'h0, 8'h00, 3'b000, 0, 0);
    apb_access(0, 32'h100, 1'b0, 64'h0, 8'h00, 3'b001, 3, 2);
    reset_mid_resp();
    apb_access(0, 32'h200, 1'b0, 64'h0, 8'h00, 3'b000, 0, 0);

    // randomized traffic
    for (int i = 0; i < 160; i++) begin
      k    = $urandom_range(0, 1);
      addr = ($urandom_range(0, 3) == 0) ? (32'hE00 | 32'($urandom_range(0, 255)))
                                         : 32'($urandom_range(0, 4095));
      wr   = 1'($urandom_range(0, 1));
      wd   = {$urandom(), $urandom()};
      strb = 8'($urandom());
      if ($urandom_range(0, 3) == 0) strb[3:0] = 4'h0;
      if ($urandom_range(0, 3) == 0) strb[7:4] = 4'h0;
      apb_access(k, addr, wr, wd, strb, 3'($urandom()),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (10) @(posedge clk);
    check("exp_obi_q_empty", exp_obi_q.size(), 0);
    check("exp_apb_q_empty", exp_apb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
